// File: rtl/modex_encryptor.sv
`default_nettype none
// ============================================================================
// Module   : modex_encryptor
// Purpose  : Modular exponentiation c = m^e mod n, right-to-left
//            square-and-multiply on two shift-add modular multipliers.
// Options  : MODEX_EARLY_TERM_EN - stop once the remaining exponent is zero.
// Revision : 1.0 - initial release
// ============================================================================
module modex_encryptor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] plain,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] encrypted,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int              c_cw       = $clog2(WIDTH + 1);
  localparam logic [c_cw-1:0] c_last_bit = c_cw'(WIDTH - 1);
  localparam logic [c_cw-1:0] c_rounds   = c_cw'(WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    MUL  = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] ba_q, ba_d;
  logic [WIDTH+1:0] pr_q, pr_d;
  logic [WIDTH+1:0] pb_q, pb_d;
  logic [c_cw-1:0]  bit_q, bit_d;
  logic [c_cw-1:0]  rnd_q, rnd_d;
  logic             operr_q, operr_d;
  logic [WIDTH-1:0] enc_q, enc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] w_r_new;
  logic [WIDTH-1:0] w_b_new;
  logic [WIDTH-1:0] w_e_shr;
  logic [c_cw-1:0]  w_rnd_inc;
  logic             w_op_err;

  // One MSB-first step: P < n on entry, so 2P + a*b < 3n and two subtractions suffice.
  function automatic logic [WIDTH+1:0] mm_step(
    input logic [WIDTH+1:0] p,
    input logic             a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] n
  );
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] nx;
    nx = {2'b00, n};
    t  = (p << 1) + (a ? {2'b00, b} : '0);
    if (t >= nx) t = t - nx;
    if (t >= nx) t = t - nx;
    return t;
  endfunction

  assign w_r_new   = e_q[0] ? pr_q[WIDTH-1:0] : r_q;
  assign w_b_new   = pb_q[WIDTH-1:0];
  assign w_e_shr   = e_q >> 1;
  assign w_rnd_inc = rnd_q + 1'b1;
  assign w_op_err  = (n_q < WIDTH'(2)) || (m_q >= n_q);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    n_d     = n_q;
    r_d     = r_q;
    b_d     = b_q;
    ra_d    = ra_q;
    ba_d    = ba_q;
    pr_d    = pr_q;
    pb_d    = pb_q;
    bit_d   = bit_q;
    rnd_d   = rnd_q;
    operr_d = operr_q;
    enc_d   = enc_q;
    busy_d  = busy_q;
    err_d   = err_q;
    done_d  = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          m_d     = plain;
          e_d     = exponent;
          n_d     = modulus;
          busy_d  = 1'b1;
        end
      end

      INIT: begin
        r_d     = WIDTH'(1);
        b_d     = m_q;
        ra_d    = WIDTH'(1);
        ba_d    = m_q;
        pr_d    = '0;
        pb_d    = '0;
        bit_d   = '0;
        rnd_d   = '0;
        operr_d = w_op_err;
        if (w_op_err) begin
          state_d = DONE;
        end
`ifdef MODEX_EARLY_TERM_EN
        else if (e_q == '0) begin
          state_d = DONE;
        end
`endif
        else begin
          state_d = MUL;
        end
      end

      MUL: begin
        pr_d  = mm_step(pr_q, ra_q[WIDTH-1], b_q, n_q);
        pb_d  = mm_step(pb_q, ba_q[WIDTH-1], b_q, n_q);
        ra_d  = ra_q << 1;
        ba_d  = ba_q << 1;
        bit_d = bit_q + 1'b1;
        if (bit_q == c_last_bit) begin
          state_d = NEXT;
        end
      end

      NEXT: begin
        r_d   = w_r_new;
        b_d   = w_b_new;
        e_d   = w_e_shr;
        rnd_d = w_rnd_inc;
        ra_d  = w_r_new;
        ba_d  = w_b_new;
        pr_d  = '0;
        pb_d  = '0;
        bit_d = '0;
`ifdef MODEX_EARLY_TERM_EN
        if ((w_e_shr == '0) || (w_rnd_inc == c_rounds)) begin
`else
        if (w_rnd_inc == c_rounds) begin
`endif
          state_d = DONE;
        end else begin
          state_d = MUL;
        end
      end

      DONE: begin
        state_d = IDLE;
        enc_d   = operr_q ? '0 : r_q;
        err_d   = operr_q;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      ra_q    <= '0;
      ba_q    <= '0;
      pr_q    <= '0;
      pb_q    <= '0;
      bit_q   <= '0;
      rnd_q   <= '0;
      operr_q <= 1'b0;
      enc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      n_q     <= n_d;
      r_q     <= r_d;
      b_q     <= b_d;
      ra_q    <= ra_d;
      ba_q    <= ba_d;
      pr_q    <= pr_d;
      pb_q    <= pb_d;
      bit_q   <= bit_d;
      rnd_q   <= rnd_d;
      operr_q <= operr_d;
      enc_q   <= enc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign encrypted = enc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire
